// File: rtl/fsm_common_pkg.sv
// -----------------------------------------------------------------------------
// fsm_common_pkg
// Definitions shared by the detector-side FSM blocks.
//   out_state_t : state of a single-entry result holding register
//                 (ST_EMPTY = nothing to report, ST_FULL = result waiting).
// -----------------------------------------------------------------------------
package fsm_common_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage : fsm_common_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its maximum value and flags any increment that
// arrives while it is already there.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   inc   : add one (ignored when clr is high)
//   clr   : return value and sat to zero; has priority over inc
//   value : current count
//   sat   : an increment was lost to saturation since the last clear
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (value == MAX) begin
                sat <= 1'b1;
            end else begin
                value <= value + 1'b1;
            end
        end
    end

endmodule : sat_counter

// File: rtl/detect_window_counter.sv
// -----------------------------------------------------------------------------
// detect_window_counter
// Counts detect pulses over windows of WINDOW_LEN enabled cycles and offers
// each window's (saturating) count on a one-entry valid/ready port.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   enable      : advances the window; timer and accumulator hold when low
//   detect_in   : detection pulse, sampled only while enable is high
//   count_ready : consumer accepts count_out while count_valid is high
//   count_out   : count of the last completed window
//   count_valid : count_out / overflow hold an unconsumed result
//   overflow    : the accumulator saturated during the reported window
//   dropped     : one-cycle pulse when a finished window found the port full
// -----------------------------------------------------------------------------
module detect_window_counter
    import fsm_common_pkg::*;
#(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             detect_in,
    input  logic             count_ready,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             dropped
);

    localparam int              TW   = $clog2(WINDOW_LEN);
    localparam logic [TW-1:0]   LAST = TW'(WINDOW_LEN - 1);

    logic [TW-1:0]    timer;
    logic             end_win;
    logic             inc;
    logic [CNT_W-1:0] acc;
    logic             acc_sat;
    logic             at_max;
    logic [CNT_W-1:0] final_cnt;
    logic             final_sat;

    out_state_t       state, state_next;
    logic             load;
    logic             drop_next;

    assign end_win = enable && (timer == LAST);
    assign inc     = enable && detect_in;

    // Window timer: free-running over enabled cycles, never stalled by the
    // output port.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (enable) begin
            timer <= end_win ? '0 : timer + 1'b1;
        end
    end

    // Accumulator clears on end_win; the detect of that cycle is folded into
    // the closing window by final_cnt/final_sat below, not carried over.
    sat_counter #(.W(CNT_W)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .clr   (end_win),
        .value (acc),
        .sat   (acc_sat)
    );

    assign at_max    = &acc;
    assign final_cnt = (inc && !at_max) ? acc + 1'b1 : acc;
    assign final_sat = acc_sat | (inc & at_max);

    // Output FSM: state register plus the result registers it controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            count_out <= '0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            state   <= state_next;
            dropped <= drop_next;
            if (load) begin
                count_out <= final_cnt;
                overflow  <= final_sat;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop_next  = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (end_win) begin
                    load       = 1'b1;
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (end_win && count_ready) begin
                    load = 1'b1;
                end else if (end_win) begin
                    // Port still occupied: keep the old result, report the loss.
                    drop_next = 1'b1;
                end else if (count_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign count_valid = (state == ST_FULL);

endmodule : detect_window_counter

// File: tb/tb_detect_window_counter.sv
// -----------------------------------------------------------------------------
// tb_detect_window_counter
// Drives two instances from the same stimulus (CNT_W=8 and CNT_W=2, both with
// WINDOW_LEN=16) and compares each against a window-level reference model that
// keeps an unbounded detect tally and clamps it only when a window closes.
// -----------------------------------------------------------------------------
module tb_detect_window_counter;

    localparam int WL = 16;

    logic       clk = 1'b0;
    logic       rst, enable, detect_in, count_ready;
    logic [7:0] c8;
    logic       v8, o8, d8;
    logic [1:0] c2;
    logic       v2, o2, d2;

    always #5 clk = ~clk;

    detect_window_counter #(.WINDOW_LEN(WL), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .detect_in(detect_in),
        .count_ready(count_ready), .count_out(c8), .count_valid(v8),
        .overflow(o8), .dropped(d8)
    );

    detect_window_counter #(.WINDOW_LEN(WL), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .detect_in(detect_in),
        .count_ready(count_ready), .count_out(c2), .count_valid(v2),
        .overflow(o2), .dropped(d2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 models the CNT_W=8 instance, index 1 CNT_W=2.
    int pos, cnt;
    int max_c [2] = '{255, 3};
    bit m_valid [2];
    int m_count [2];
    bit m_ovf   [2];
    bit m_drop  [2];

    task automatic model_edge();
        bit we;
        bit hs;
        if (rst) begin
            pos = 0;
            cnt = 0;
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 0; m_count[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
            end
        end else begin
            we = enable && (pos == WL - 1);
            if (enable) begin
                cnt = cnt + int'(detect_in);
                pos = (pos + 1) % WL;
            end
            for (int k = 0; k < 2; k++) begin
                m_drop[k] = 0;
                hs = m_valid[k] && count_ready;
                if (we) begin
                    if (!m_valid[k] || hs) begin
                        m_valid[k] = 1;
                        m_count[k] = (cnt > max_c[k]) ? max_c[k] : cnt;
                        m_ovf[k]   = (cnt > max_c[k]);
                    end else begin
                        m_drop[k] = 1;
                    end
                end else if (hs) begin
                    m_valid[k] = 0;
                end
            end
            if (we) cnt = 0;
        end
    endtask

    function automatic logic [10:0] exp8();
        logic [7:0] c = m_count[0][7:0];
        return {m_valid[0], c, m_ovf[0], m_drop[0]};
    endfunction

    function automatic logic [4:0] exp2();
        logic [1:0] c = m_count[1][1:0];
        return {m_valid[1], c, m_ovf[1], m_drop[1]};
    endfunction

    // Inputs are changed only at the falling edge; the model sees the same
    // values the DUT samples at the rising edge; outputs are read at the next
    // falling edge.
    task automatic clock_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit e, input bit d, input bit rdy);
        rst = r; enable = e; detect_in = d; count_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0);
        clock_cycle();
        clock_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1);
        clock_cycle();
        clock_cycle();
        total++;
        if ({v8, c8, o8, d8} !== 11'd0) begin
            bad++; $display("FAIL reset w8: got %h want 000", {v8, c8, o8, d8});
        end
        total++;
        if ({v2, c2, o2, d2} !== 5'd0) begin
            bad++; $display("FAIL reset w2: got %h want 00", {v2, c2, o2, d2});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int vcyc = 0, seen = -1, first = -1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(0, 1, (i == 2 || i == 5 || i == 9), 1);
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL basic w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            if (v8) begin vcyc++; seen = int'(c8); if (first < 0) first = i; end
        end
        total++;
        if (vcyc != 1 || seen != 3 || first != 15) begin
            bad++; $display("FAIL basic report: got cycles=%0d count=%0d at=%0d want 1/3/15", vcyc, seen, first);
        end
    endtask

    task automatic test_boundary();
        int reps[$];
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, (i == 15 || i == 16), 1);
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL boundary w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            if (v8) reps.push_back(int'(c8));
        end
        total++;
        if (reps.size() != 2 || reps[0] != 1 || reps[1] != 1) begin
            bad++; $display("FAIL boundary reports: got n=%0d want two reports of 1", reps.size());
        end
    endtask

    task automatic test_saturation();
        int rc[$];
        int ro[$];
        do_reset();
        for (int i = 0; i < 34; i++) begin
            drive(0, 1, ((i >= 1 && i <= 5) || i == 20), 1);
            clock_cycle();
            total++;
            if ({v2, c2, o2, d2} !== exp2()) begin
                bad++; $display("FAIL sat w2 i=%0d: got %h want %h", i, {v2, c2, o2, d2}, exp2());
            end
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL sat w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            if (v2) begin rc.push_back(int'(c2)); ro.push_back(int'(o2)); end
        end
        total++;
        if (rc.size() != 2 || rc[0] != 3 || ro[0] != 1 || rc[1] != 1 || ro[1] != 0) begin
            bad++; $display("FAIL sat reports: got n=%0d want (3,ovf1),(1,ovf0)", rc.size());
        end
    endtask

    task automatic test_backpressure();
        int drops = 0;
        do_reset();
        for (int i = 0; i < 33; i++) begin
            drive(0, 1, ((i >= 1 && i <= 4) || (i >= 17 && i <= 22)), (i == 32));
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL backpressure w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            if (d8) drops++;
            if (i >= 15 && i < 32) begin
                total++;
                if (!v8 || c8 !== 8'd4) begin
                    bad++; $display("FAIL backpressure hold i=%0d: got v=%b c=%0d want v=1 c=4", i, v8, c8);
                end
            end
        end
        total++;
        if (drops != 1 || v8 !== 1'b0) begin
            bad++; $display("FAIL backpressure end: got drops=%0d v=%b want 1/0", drops, v8);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 34; i++) begin
            drive(0, 1, ((i >= 1 && i <= 2) || (i >= 17 && i <= 23)), (i == 31));
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL simul w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            if (i >= 31) begin
                total++;
                if ({v8, c8, d8} !== {1'b1, 8'd7, 1'b0}) begin
                    bad++; $display("FAIL simul result i=%0d: got v=%b c=%0d d=%b want 1/7/0", i, v8, c8, d8);
                end
            end
        end
    endtask

    task automatic test_enable_reset();
        int first = -1, seen = -1;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            drive(0, !(i >= 6 && i < 16), (i == 3 || i == 4 || (i >= 6 && i < 16)), 1);
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL enable w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            if (v8 && first < 0) begin first = i; seen = int'(c8); end
        end
        total++;
        if (first != 25 || seen != 2) begin
            bad++; $display("FAIL enable report: got at=%0d count=%0d want 25/2", first, seen);
        end
        // Held result plus a partial window of 3, then reset at window cycle 8.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive((i == 24), 1, (i == 5 || (i >= 17 && i <= 19)), 0);
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL midreset w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
        end
        total++;
        if (v8 !== 1'b0 || d8 !== 1'b0) begin
            bad++; $display("FAIL midreset valid: got v=%b d=%b want 0/0", v8, d8);
        end
        seen = -1;
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, (i == 2 || i == 7), 1);
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL postreset w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            if (v8) seen = int'(c8);
        end
        total++;
        if (seen != 2) begin
            bad++; $display("FAIL postreset report: got %0d want 2", seen);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(199) == 0), ($urandom_range(9) < 8),
                  ($urandom_range(9) < 4), ($urandom_range(9) < 4));
            clock_cycle();
            total++;
            if ({v8, c8, o8, d8} !== exp8()) begin
                bad++; $display("FAIL random w8 i=%0d: got %h want %h", i, {v8, c8, o8, d8}, exp8());
            end
            total++;
            if ({v2, c2, o2, d2} !== exp2()) begin
                bad++; $display("FAIL random w2 i=%0d: got %h want %h", i, {v2, c2, o2, d2}, exp2());
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundary();
        test_saturation();
        test_backpressure();
        test_simultaneous();
        test_enable_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_detect_window_counter
